// File: rtl/doc_wave_pkg.sv
// doc_wave_pkg: state/source types and default constants
// shared by the DOC5503 wave-fetch responder.
package doc_wave_pkg;

    localparam int         DOC_ADDR_W       = 16;
    localparam int         DOC_TIMEOUT_CYC  = 64;
    localparam logic [7:0] DOC_SILENCE_BYTE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DONE
    } state_e;

    typedef enum logic {
        SRC_DOC,
        SRC_HOST
    } src_e;

endpackage

// File: rtl/doc_wave_responder.sv
// doc_wave_responder: serves DOC5503 wave byte fetches and host (GLU)
// byte reads/writes from one variable-latency backing store.
// Ports: clk_i/reset_i (sync, active high); DOC side wave_address_i,
// wave_rd_i, wave_data_ready_o, wave_data_o; host side host_addr_i,
// host_rd_i, host_wr_i, host_data_i, host_data_o, host_ack_o; store side
// mem_addr_o, mem_rd_o, mem_wr_o, mem_data_o, mem_data_i, mem_valid_i.
// Option: define DOC_WAVE_CACHE_EN for a single-entry DOC read cache.
module doc_wave_responder
    import doc_wave_pkg::*;
#(
    parameter int         ADDR_W       = DOC_ADDR_W,
    parameter int         TIMEOUT_CYC  = DOC_TIMEOUT_CYC,
    parameter logic [7:0] SILENCE_BYTE = DOC_SILENCE_BYTE
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] wave_address_i,
    input  logic              wave_rd_i,
    output logic              wave_data_ready_o,
    output logic [7:0]        wave_data_o,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic              host_rd_i,
    input  logic              host_wr_i,
    input  logic [7:0]        host_data_i,
    output logic [7:0]        host_data_o,
    output logic              host_ack_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [7:0]        mem_data_o,
    input  logic [7:0]        mem_data_i,
    input  logic              mem_valid_i
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_e            state_q;
    src_e              src_q;
    logic              wr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wave_rdy_q;
    logic              host_ack_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [7:0]        wave_data_q;
    logic [7:0]        host_data_q;
    logic [7:0]        mem_data_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              host_req_d;
    logic              timeout_d;
    logic [7:0]        resp_byte_d;

`ifdef DOC_WAVE_CACHE_EN
    logic              cache_valid_q;
    logic [ADDR_W-1:0] cache_addr_q;
    logic [7:0]        cache_byte_q;
    logic              cache_hit_d;

    always_comb begin
        cache_hit_d = cache_valid_q && (cache_addr_q == wave_address_i);
    end
`endif

    // A late store response wins over a timeout in the same cycle.
    always_comb begin
        host_req_d  = host_rd_i | host_wr_i;
        timeout_d   = (cnt_q == CNT_MAX);
        resp_byte_d = mem_valid_i ? mem_data_i : SILENCE_BYTE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            src_q       <= SRC_DOC;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            wave_rdy_q  <= 1'b0;
            host_ack_q  <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            wave_data_q <= '0;
            host_data_q <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
`ifdef DOC_WAVE_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_byte_q  <= '0;
`endif
        end else begin
            wave_rdy_q <= 1'b0;
            host_ack_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (wave_rd_i) begin
                        src_q <= SRC_DOC;
                        wr_q  <= 1'b0;
`ifdef DOC_WAVE_CACHE_EN
                        if (cache_hit_d) begin
                            wave_data_q <= cache_byte_q;
                            wave_rdy_q  <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            mem_addr_q <= wave_address_i;
                            mem_rd_q   <= 1'b1;
                            state_q    <= ISSUE;
                        end
`else
                        mem_addr_q <= wave_address_i;
                        mem_rd_q   <= 1'b1;
                        state_q    <= ISSUE;
`endif
                    end else if (host_req_d) begin
                        // write beats read when both are raised
                        src_q      <= SRC_HOST;
                        wr_q       <= host_wr_i;
                        mem_addr_q <= host_addr_i;
                        mem_rd_q   <= ~host_wr_i;
                        mem_wr_q   <= host_wr_i;
                        if (host_wr_i) begin
                            mem_data_q <= host_data_i;
                        end
`ifdef DOC_WAVE_CACHE_EN
                        if (host_wr_i && cache_valid_q &&
                            (cache_addr_q == host_addr_i)) begin
                            cache_byte_q <= host_data_i;
                        end
`endif
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_valid_i || timeout_d) begin
                        state_q <= RESP;
                        if (src_q == SRC_DOC) begin
                            wave_data_q <= resp_byte_d;
                            wave_rdy_q  <= 1'b1;
`ifdef DOC_WAVE_CACHE_EN
                            if (mem_valid_i) begin
                                cache_valid_q <= 1'b1;
                                cache_addr_q  <= mem_addr_q;
                                cache_byte_q  <= mem_data_i;
                            end
`endif
                        end else begin
                            host_ack_q <= 1'b1;
                            if (!wr_q) begin
                                host_data_q <= resp_byte_d;
                            end
                        end
                    end else begin
                        // only reached below CNT_MAX, so it never wraps
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wave_data_ready_o = wave_rdy_q;
    assign wave_data_o       = wave_data_q;
    assign host_ack_o        = host_ack_q;
    assign host_data_o       = host_data_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_rd_o          = mem_rd_q;
    assign mem_wr_o          = mem_wr_q;
    assign mem_data_o        = mem_data_q;

endmodule

// File: tb/tb_doc_wave_responder.sv
// tb_doc_wave_responder: directed and randomized checks of the
// DOC wave responder against a byte-store model and timing rules.
module tb_doc_wave_responder;

    localparam int         TMO = 64;
    localparam logic [7:0] SIL = 8'h80;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [15:0] wave_address_i = '0;
    logic        wave_rd_i = 1'b0;
    logic        wave_data_ready_o;
    logic [7:0]  wave_data_o;
    logic [15:0] host_addr_i = '0;
    logic        host_rd_i = 1'b0;
    logic        host_wr_i = 1'b0;
    logic [7:0]  host_data_i = '0;
    logic [7:0]  host_data_o;
    logic        host_ack_o;
    logic [15:0] mem_addr_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic [7:0]  mem_data_o;
    logic [7:0]  mem_data_i;
    logic        mem_valid_i;

    doc_wave_responder dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .wave_address_i    (wave_address_i),
        .wave_rd_i         (wave_rd_i),
        .wave_data_ready_o (wave_data_ready_o),
        .wave_data_o       (wave_data_o),
        .host_addr_i       (host_addr_i),
        .host_rd_i         (host_rd_i),
        .host_wr_i         (host_wr_i),
        .host_data_i       (host_data_i),
        .host_data_o       (host_data_o),
        .host_ack_o        (host_ack_o),
        .mem_addr_o        (mem_addr_o),
        .mem_rd_o          (mem_rd_o),
        .mem_wr_o          (mem_wr_o),
        .mem_data_o        (mem_data_o),
        .mem_data_i        (mem_data_i),
        .mem_valid_i       (mem_valid_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mem_lat = 0;

    logic [7:0] store [0:65535];

    // reference state: last host read byte and the DOC cache entry
    logic [7:0]  host_hold = 8'h00;
    bit          c_valid = 1'b0;
    logic [15:0] c_addr = '0;
    logic [7:0]  c_byte = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // backing store: answers a strobe with mem_valid_i in WAIT cycle
    // number mem_lat (0 = first WAIT cycle); out-of-range means never
    initial begin
        logic [15:0] a;
        mem_valid_i = 1'b0;
        mem_data_i  = 8'h00;
        for (int i = 0; i < 65536; i++) begin
            store[i] = 8'($urandom);
        end
        forever begin
            @(negedge clk);
            if (mem_rd_o || mem_wr_o) begin
                a = mem_addr_o;
                if (mem_wr_o) begin
                    store[a] = mem_data_o;
                end
                if (mem_lat >= 0 && mem_lat < TMO) begin
                    repeat (mem_lat + 1) @(negedge clk);
                    mem_valid_i = 1'b1;
                    mem_data_i  = store[a];
                    @(negedge clk);
                    mem_valid_i = 1'b0;
                    mem_data_i  = 8'($urandom);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // a store access answers 3 cycles after the request plus the WAIT
    // cycles spent; waiting gives up after TMO WAIT cycles
    function automatic int store_lat(input int lat);
        return 3 + ((lat < 0 || lat > TMO - 1) ? TMO - 1 : lat);
    endfunction

    function automatic bit in_time(input int lat);
        return lat >= 0 && lat < TMO;
    endfunction

    task automatic doc_read(input logic [15:0] a, input int lat,
                            input string tag);
        int t0, nrd, lat_exp;
        logic [7:0] d_exp;
        logic [15:0] ra;
        bit hit, got;
        hit = 1'b0;
`ifdef DOC_WAVE_CACHE_EN
        hit = c_valid && (c_addr == a);
`endif
        lat_exp = hit ? 1 : store_lat(lat);
        d_exp = hit ? c_byte : (in_time(lat) ? store[a] : SIL);
        mem_lat = lat;
        @(negedge clk);
        wave_address_i = a;
        wave_rd_i = 1'b1;
        t0 = cyc;
        nrd = 0;
        got = 1'b0;
        ra = '0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (mem_rd_o) begin
                nrd++;
                ra = mem_addr_o;
            end
            if (wave_data_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        wave_rd_i = 1'b0;
        chk({tag, ".ready"}, 32'(got), 32'd1);
        chk({tag, ".lat"}, 32'(cyc - t0), 32'(lat_exp));
        chk({tag, ".data"}, 32'(wave_data_o), 32'(d_exp));
        chk({tag, ".nrd"}, 32'(nrd), hit ? 32'd0 : 32'd1);
        if (!hit) begin
            chk({tag, ".addr"}, 32'(ra), 32'(a));
        end
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(wave_data_ready_o), 32'd0);
        chk({tag, ".hold"}, 32'(wave_data_o), 32'(d_exp));
        if (!hit && in_time(lat)) begin
            c_valid = 1'b1;
            c_addr  = a;
            c_byte  = d_exp;
        end
    endtask

    task automatic host_op(input bit wr, input bit rd, input logic [15:0] a,
                           input logic [7:0] d, input int lat,
                           input string tag);
        int t0, nrd, nwr;
        logic [7:0] d_exp, wd;
        logic [15:0] ma;
        bit got;
        d_exp = wr ? host_hold : (in_time(lat) ? store[a] : SIL);
        mem_lat = lat;
        @(negedge clk);
        host_addr_i = a;
        host_data_i = d;
        host_wr_i = wr;
        host_rd_i = rd;
        t0 = cyc;
        nrd = 0;
        nwr = 0;
        got = 1'b0;
        ma = '0;
        wd = '0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (mem_rd_o) begin
                nrd++;
                ma = mem_addr_o;
            end
            if (mem_wr_o) begin
                nwr++;
                ma = mem_addr_o;
                wd = mem_data_o;
            end
            if (host_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        host_wr_i = 1'b0;
        host_rd_i = 1'b0;
        chk({tag, ".ack"}, 32'(got), 32'd1);
        chk({tag, ".lat"}, 32'(cyc - t0), 32'(store_lat(lat)));
        chk({tag, ".data"}, 32'(host_data_o), 32'(d_exp));
        chk({tag, ".nrd"}, 32'(nrd), wr ? 32'd0 : 32'd1);
        chk({tag, ".nwr"}, 32'(nwr), wr ? 32'd1 : 32'd0);
        chk({tag, ".addr"}, 32'(ma), 32'(a));
        if (wr) begin
            chk({tag, ".wdata"}, 32'(wd), 32'(d));
        end
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(host_ack_o), 32'd0);
        host_hold = d_exp;
        if (wr && c_valid && c_addr == a) begin
            c_byte = d;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rdy"}, 32'(wave_data_ready_o), 32'd0);
        chk({tag, ".ack"}, 32'(host_ack_o), 32'd0);
        chk({tag, ".strb"}, 32'({mem_rd_o, mem_wr_o}), 32'd0);
        chk({tag, ".wdat"}, 32'(wave_data_o), 32'd0);
        chk({tag, ".hdat"}, 32'(host_data_o), 32'd0);
        chk({tag, ".madr"}, 32'(mem_addr_o), 32'd0);
        chk({tag, ".mdat"}, 32'(mem_data_o), 32'd0);
    endtask

    initial begin
        int t0, early, nwr, nack;
        logic [15:0] wa;
        logic [7:0] wd, d_exp;
        bit got;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset_i = 1'b0;

        // single read, data two WAIT cycles in
        doc_read(16'h1234, 1, "t1");
        doc_read(16'h4321, 0, "minlat");

        // simultaneous DOC read and host write: DOC first
        mem_lat = 1;
        d_exp = store[16'h3456];
        @(negedge clk);
        wave_address_i = 16'h3456;
        wave_rd_i = 1'b1;
        host_addr_i = 16'h0010;
        host_data_i = 8'hC3;
        host_wr_i = 1'b1;
        early = 0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (host_ack_o || mem_wr_o) early++;
            if (wave_data_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        wave_rd_i = 1'b0;
        chk("t2.doc_ready", 32'(got), 32'd1);
        chk("t2.doc_first", 32'(early), 32'd0);
        chk("t2.doc_data", 32'(wave_data_o), 32'(d_exp));
        c_valid = 1'b1;
        c_addr = 16'h3456;
        c_byte = d_exp;
        nwr = 0;
        nack = 0;
        wa = '0;
        wd = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_wr_o) begin
                nwr++;
                wa = mem_addr_o;
                wd = mem_data_o;
            end
            if (host_ack_o) begin
                nack++;
                break;
            end
        end
        host_wr_i = 1'b0;
        @(negedge clk);
        if (host_ack_o) nack++;
        chk("t2.ack", 32'(nack), 32'd1);
        chk("t2.nwr", 32'(nwr), 32'd1);
        chk("t2.waddr", 32'(wa), 32'h0010);
        chk("t2.wdata", 32'(wd), 32'hC3);

        // timeout boundary: last WAIT cycle answered, then none
        doc_read(16'h5555, TMO - 1, "edge63");
        doc_read(16'h6666, TMO, "t3.tmo");
        host_op(1'b0, 1'b1, 16'h7777, 8'h00, 200, "hrd.tmo");

        // write beats read when both are raised
        host_op(1'b1, 1'b1, 16'h0042, 8'h9D, 2, "rw.both");
        host_op(1'b0, 1'b1, 16'h0042, 8'h00, 0, "rw.read");

        // reset while waiting; the late response lands in IDLE
        mem_lat = 8;
        @(negedge clk);
        wave_address_i = 16'hABCD;
        wave_rd_i = 1'b1;
        repeat (5) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        wave_rd_i = 1'b0;
        early = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wave_data_ready_o || host_ack_o) early++;
        end
        chk("t4.quiet", 32'(early), 32'd0);
        chk_reset_vals("t4");
        host_hold = 8'h00;
        c_valid = 1'b0;
        doc_read(16'hABCD, 2, "t4.after");

        // repeat read of one address, then host write to it
        doc_read(16'h2000, 1, "t5.a");
        doc_read(16'h2000, 1, "t5.b");
        host_op(1'b1, 1'b0, 16'h2000, 8'h77, 1, "t5.wr");
        doc_read(16'h2000, 2, "t5.c");
        chk("t5.val", 32'(wave_data_o), 32'h77);

        // randomized mix over a small address pool
        for (int n = 0; n < 30; n++) begin
            logic [15:0] ra;
            int kind, lat;
            kind = int'($urandom_range(0, 2));
            lat = int'($urandom_range(0, 6));
            ra = ($urandom_range(0, 1) == 0) ? 16'h2000 : 16'($urandom);
            case (kind)
                0: doc_read(ra, lat, "rnd.doc");
                1: host_op(1'b1, 1'b0, ra, 8'($urandom), lat, "rnd.hwr");
                default: host_op(1'b0, 1'b1, ra, 8'h00, lat, "rnd.hrd");
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
